// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Priority encodings and register-index sizing.
package regfile_write_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef enum logic {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } prio_e;

endpackage

// File: rtl/regfile_write_arbiter_decoder5to32.sv
// 5-to-32 one-hot decoder with enable.
// Output is all-zero when enable is low.
module decoder5to32
    import regfile_write_arbiter_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  dec
);

    // One-hot expansion of the index, gated by enable
    always_comb begin
        dec = '0;
        if (en) begin
            dec[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port
// between the ALU (A) and load (B) writeback paths.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 HOLD,
    input  logic                 A_VALID,
    input  logic [REG_IDX_W-1:0] A_RD,
    input  logic [WIDTH-1:0]     A_DATA,
    output logic                 A_READY,
    input  logic                 B_VALID,
    input  logic [REG_IDX_W-1:0] B_RD,
    input  logic [WIDTH-1:0]     B_DATA,
    output logic                 B_READY,
    output logic [NUM_REGS-1:0]  WE,
    output logic [REG_IDX_W-1:0] WADDR,
    output logic [WIDTH-1:0]     WDATA,
    output logic                 GRANT_B,
    output logic [CNT_W-1:0]     CONFLICT_CNT
);

    prio_e                prio_q;
    prio_e                prio_d;
    logic                 a_grant;
    logic                 b_grant;
    logic                 accept;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [WIDTH-1:0]     sel_data;
    logic                 dec_en;
    logic [NUM_REGS-1:0]  dec_we;
    logic                 conflict;

    // Grant decode: hold blocks all, a lone requester wins, ties go to prio
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (!RST && !HOLD) begin
            if (A_VALID && B_VALID) begin
                a_grant = (prio_q == PREF_A);
                b_grant = (prio_q == PREF_B);
            end else begin
                a_grant = A_VALID;
                b_grant = B_VALID;
            end
        end
    end

    assign A_READY  = a_grant;
    assign B_READY  = b_grant;
    assign accept   = a_grant | b_grant;
    assign sel_rd   = b_grant ? B_RD : A_RD;
    assign sel_data = b_grant ? B_DATA : A_DATA;
    assign dec_en   = accept && (sel_rd != '0);
    assign conflict = A_VALID && B_VALID && !HOLD;

    // Priority next state: favour the side that just lost
    always_comb begin
        prio_d = prio_q;
        unique case (1'b1)
            a_grant: prio_d = PREF_B;
            b_grant: prio_d = PREF_A;
            default: prio_d = prio_q;
        endcase
    end

    // Priority state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prio_q <= PREF_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    decoder5to32 u_dec (
        .idx (sel_rd),
        .en  (dec_en),
        .dec (dec_we)
    );

    // Output stage: WE pulses per accept, address/data/source hold otherwise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WE      <= '0;
            WADDR   <= '0;
            WDATA   <= '0;
            GRANT_B <= 1'b0;
        end else begin
            WE <= dec_we;
            if (accept) begin
                WADDR   <= sel_rd;
                WDATA   <= sel_data;
                GRANT_B <= b_grant;
            end
        end
    end

    // Saturating count of cycles with competing requests
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CONFLICT_CNT <= '0;
        end else if (conflict && (CONFLICT_CNT != '1)) begin
            CONFLICT_CNT <= CONFLICT_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter.
// Directed table, corner sequences and a randomized model run.
module tb_regfile_write_arbiter;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          HOLD = 1'b0;
    logic          A_VALID = 1'b0;
    logic [4:0]    A_RD = '0;
    logic [W-1:0]  A_DATA = '0;
    logic          A_READY;
    logic          B_VALID = 1'b0;
    logic [4:0]    B_RD = '0;
    logic [W-1:0]  B_DATA = '0;
    logic          B_READY;
    logic [31:0]   WE;
    logic [4:0]    WADDR;
    logic [W-1:0]  WDATA;
    logic          GRANT_B;
    logic [CW-1:0] CONFLICT_CNT;

    regfile_write_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .HOLD         (HOLD),
        .A_VALID      (A_VALID),
        .A_RD         (A_RD),
        .A_DATA       (A_DATA),
        .A_READY      (A_READY),
        .B_VALID      (B_VALID),
        .B_RD         (B_RD),
        .B_DATA       (B_DATA),
        .B_READY      (B_READY),
        .WE           (WE),
        .WADDR        (WADDR),
        .WDATA        (WDATA),
        .GRANT_B      (GRANT_B),
        .CONFLICT_CNT (CONFLICT_CNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          hold;
        bit          av;
        logic [4:0]  ard;
        logic [31:0] ad;
        bit          bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        bit          ar;
        bit          br;
        logic [31:0] we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          gb;
        int          cnt;
    } vec_t;

    vec_t tbl[12];

    // Reference model state: who is preferred, and expected output registers
    bit          m_prefb;
    int          m_cnt;
    logic [31:0] m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          m_gb;

    task automatic model_reset();
        m_prefb = 1'b0;
        m_cnt   = 0;
        m_we    = '0;
        m_wa    = '0;
        m_wd    = '0;
        m_gb    = 1'b0;
    endtask

    task automatic drive(input bit h, input bit av, input logic [4:0] ard,
                         input logic [31:0] ad, input bit bv,
                         input logic [4:0] brd, input logic [31:0] bd);
        HOLD    = h;
        A_VALID = av;
        A_RD    = ard;
        A_DATA  = ad;
        B_VALID = bv;
        B_RD    = brd;
        B_DATA  = bd;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    // One model-checked cycle with the current inputs on the bus
    task automatic model_cycle();
        bit ga;
        bit gb;
        ga = 0;
        gb = 0;
        if (!HOLD) begin
            if (A_VALID && B_VALID) begin
                ga = !m_prefb;
                gb = m_prefb;
            end else begin
                ga = A_VALID;
                gb = B_VALID;
            end
        end
        #1;
        chk("rnd_a_ready", {31'b0, A_READY}, {31'b0, ga});
        chk("rnd_b_ready", {31'b0, B_READY}, {31'b0, gb});
        if (A_VALID && B_VALID && !HOLD && m_cnt < CMAX) m_cnt++;
        m_we = '0;
        if (ga || gb) begin
            m_wa    = gb ? B_RD : A_RD;
            m_wd    = gb ? B_DATA : A_DATA;
            m_gb    = gb;
            m_we    = (m_wa == 0) ? 32'h0 : (32'h1 << m_wa);
            m_prefb = ga;
        end
        @(posedge CLK);
        #1;
        chk("rnd_we", WE, m_we);
        chk("rnd_waddr", {27'b0, WADDR}, {27'b0, m_wa});
        chk("rnd_wdata", WDATA, m_wd);
        chk("rnd_grant_b", {31'b0, GRANT_B}, {31'b0, m_gb});
        chk("rnd_cnt", {28'b0, CONFLICT_CNT}, m_cnt);
    endtask

    initial begin
        bit          pa;
        bit          pb;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] da;
        logic [31:0] db;
        bit          h;

        tbl[0]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0,
                    1, 0, 32'h20, 5, 32'hDEADBEEF, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,
                    0, 0, 32'h0, 5, 32'hDEADBEEF, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 1, 0, 32'h1234,
                    0, 1, 32'h0, 0, 32'h1234, 1, 0};
        tbl[3]  = '{0, 1, 1, 32'h11, 1, 2, 32'h22,
                    1, 0, 32'h2, 1, 32'h11, 0, 1};
        tbl[4]  = '{0, 1, 1, 32'h11, 1, 2, 32'h22,
                    0, 1, 32'h4, 2, 32'h22, 1, 2};
        tbl[5]  = '{0, 1, 1, 32'h11, 1, 2, 32'h22,
                    1, 0, 32'h2, 1, 32'h11, 0, 3};
        tbl[6]  = '{0, 1, 1, 32'h11, 1, 2, 32'h22,
                    0, 1, 32'h4, 2, 32'h22, 1, 4};
        tbl[7]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,
                    0, 0, 32'h0, 2, 32'h22, 1, 4};
        tbl[8]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,
                    0, 0, 32'h0, 2, 32'h22, 1, 4};
        tbl[9]  = '{1, 1, 1, 32'h11, 1, 2, 32'h22,
                    0, 0, 32'h0, 2, 32'h22, 1, 4};
        tbl[10] = '{0, 1, 1, 32'h11, 1, 2, 32'h22,
                    1, 0, 32'h2, 1, 32'h11, 0, 5};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0,
                    0, 0, 32'h0, 1, 32'h11, 0, 5};

        // Asynchronous reset between edges
        #3;
        RST = 1'b1;
        #1;
        chk("rst_we", WE, 32'h0);
        chk("rst_waddr", {27'b0, WADDR}, 32'h0);
        chk("rst_wdata", WDATA, 32'h0);
        chk("rst_grant_b", {31'b0, GRANT_B}, 32'h0);
        chk("rst_cnt", {28'b0, CONFLICT_CNT}, 32'h0);
        A_VALID = 1'b1;
        B_VALID = 1'b1;
        #1;
        chk("rst_a_ready", {31'b0, A_READY}, 32'h0);
        chk("rst_b_ready", {31'b0, B_READY}, 32'h0);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            chk("idle_we", WE, 32'h0);
        end

        // Directed table
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].hold, tbl[i].av, tbl[i].ard, tbl[i].ad,
                  tbl[i].bv, tbl[i].brd, tbl[i].bd);
            #1;
            chk($sformatf("tbl%0d_a_ready", i), {31'b0, A_READY}, {31'b0, tbl[i].ar});
            chk($sformatf("tbl%0d_b_ready", i), {31'b0, B_READY}, {31'b0, tbl[i].br});
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d_we", i), WE, tbl[i].we);
            chk($sformatf("tbl%0d_waddr", i), {27'b0, WADDR}, {27'b0, tbl[i].wa});
            chk($sformatf("tbl%0d_wdata", i), WDATA, tbl[i].wd);
            chk($sformatf("tbl%0d_grant_b", i), {31'b0, GRANT_B}, {31'b0, tbl[i].gb});
            chk($sformatf("tbl%0d_cnt", i), {28'b0, CONFLICT_CNT}, tbl[i].cnt);
        end

        // Conflict from reset: A,B,A,B and count of 4
        do_reset();
        drive(0, 1, 1, 32'hA, 1, 2, 32'hB);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            chk("conf_we", WE, (i % 2 == 0) ? 32'h2 : 32'h4);
            chk("conf_grant_b", {31'b0, GRANT_B}, (i % 2 == 0) ? 32'h0 : 32'h1);
        end
        chk("conf_cnt", {28'b0, CONFLICT_CNT}, 32'd4);

        // Saturation of the conflict counter
        for (int i = 0; i < 16; i++) @(posedge CLK);
        #1;
        chk("sat_cnt", {28'b0, CONFLICT_CNT}, CMAX);
        @(posedge CLK);
        #1;
        chk("sat_hold_cnt", {28'b0, CONFLICT_CNT}, CMAX);

        // Reset while a write is on the bus
        do_reset();
        drive(0, 1, 7, 32'h77, 0, 0, 0);
        @(posedge CLK);
        #1;
        chk("mid_we_before", WE, 32'h80);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_we_after", WE, 32'h0);
        chk("mid_waddr_after", {27'b0, WADDR}, 32'h0);
        chk("mid_a_ready", {31'b0, A_READY}, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Randomized run against the reference model
        pa = 0;
        pb = 0;
        ra = '0;
        rb = '0;
        da = '0;
        db = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa || A_READY) begin
                pa = ($urandom_range(0, 2) != 0);
                ra = 5'($urandom_range(0, 31));
                da = $urandom;
            end
            if (!pb || B_READY) begin
                pb = ($urandom_range(0, 2) != 0);
                rb = 5'($urandom_range(0, 31));
                db = $urandom;
            end
            h = ($urandom_range(0, 3) == 0);
            drive(h, pa, ra, da, pb, rb, db);
            model_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
